// File: rtl/quant_wb_ctrl.sv
// Accumulator-row quantize/write-back controller; optional QUANT_SAT_CNT_EN adds sat_count.
// One cycle from row accept to SRAM write; acc_ready drops once the job's row quota is taken.
module quant_wb_ctrl #(
  parameter int ARRAY_SIZE        = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int OUTPUT_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH        = 10
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [ADDR_WIDTH-1:0]                       num_rows,
  input  logic [ADDR_WIDTH-1:0]                       base_addr,
  input  logic                                        acc_valid,
  output logic                                        acc_ready,
  input  logic [ARRAY_SIZE*(2*DATA_WIDTH+5)-1:0]      acc_data,
  output logic [ARRAY_SIZE*(2*DATA_WIDTH+5)-1:0]      quant_in,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]     quant_out,
  output logic                                        sram_wen,
  output logic [ADDR_WIDTH-1:0]                       sram_addr,
  output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]     sram_wdata,
  output logic                                        busy,
  output logic                                        done
`ifdef QUANT_SAT_CNT_EN
  ,
  output logic [15:0]                                 sat_count
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]                   rows_q, rows_d;
  logic [ADDR_WIDTH-1:0]                   base_q, base_d;
  logic [ADDR_WIDTH-1:0]                   row_cnt_q, row_cnt_d;
  logic [ADDR_WIDTH-1:0]                   addr_q, addr_d;
  logic                                    wen_q, wen_d;
  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                                    accept;

  assign quant_in   = acc_data;
  assign sram_wen   = wen_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

  always_comb begin
    state_d   = state_q;
    rows_d    = rows_q;
    base_d    = base_q;
    row_cnt_d = row_cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wen_d     = 1'b0;
    acc_ready = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rows_d    = num_rows;
          base_d    = base_addr;
          row_cnt_d = '0;
          state_d   = (num_rows == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        acc_ready = (row_cnt_q < rows_q);
        accept    = acc_valid && acc_ready;
        if (accept) begin
          // Address derives from the row index so valid gaps never skip an address.
          wen_d     = 1'b1;
          wdata_d   = quant_out;
          addr_d    = base_q + row_cnt_q;
          row_cnt_d = row_cnt_q + 1'b1;
          if (row_cnt_d == rows_q) state_d = DRAIN;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rows_q    <= '0;
      base_q    <= '0;
      row_cnt_q <= '0;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rows_q    <= rows_d;
      base_q    <= base_d;
      row_cnt_q <= row_cnt_d;
      addr_q    <= addr_d;
      wen_q     <= wen_d;
      wdata_q   <= wdata_d;
    end
  end

`ifdef QUANT_SAT_CNT_EN
  localparam logic [OUTPUT_DATA_WIDTH-1:0] SAT_POS = {1'b0, {(OUTPUT_DATA_WIDTH-1){1'b1}}};
  localparam logic [OUTPUT_DATA_WIDTH-1:0] SAT_NEG = {1'b1, {(OUTPUT_DATA_WIDTH-1){1'b0}}};

  logic [15:0] sat_q, sat_d;
  logic [16:0] row_sat;
  logic [16:0] sat_sum;

  assign sat_count = sat_q;

  always_comb begin
    row_sat = '0;
    sat_sum = '0;
    sat_d   = sat_q;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      if (quant_out[i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH] == SAT_POS ||
          quant_out[i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH] == SAT_NEG)
        row_sat = row_sat + 17'd1;
    end
    if (state_q == IDLE && start) begin
      sat_d = '0;
    end else if (accept) begin
      sat_sum = {1'b0, sat_q} + row_sat;
      sat_d   = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_q <= '0;
    else     sat_q <= sat_d;
  end
`endif

endmodule

// File: tb/tb_quant_wb_ctrl.sv
// Randomized scoreboard bench for quant_wb_ctrl with a behavioural quantizer on quant_in/quant_out.
module tb_quant_wb_ctrl;
  localparam int AS    = 32;
  localparam int DW    = 32;
  localparam int OW    = 32;
  localparam int AW    = 10;
  localparam int ACC_W = 2*DW+5;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  start = 1'b0;
  logic [AW-1:0]         num_rows = '0;
  logic [AW-1:0]         base_addr = '0;
  logic                  acc_valid = 1'b0;
  logic                  acc_ready;
  logic [AS*ACC_W-1:0]   acc_data = '0;
  logic [AS*ACC_W-1:0]   quant_in;
  logic [AS*OW-1:0]      quant_out;
  logic                  sram_wen;
  logic [AW-1:0]         sram_addr;
  logic [AS*OW-1:0]      sram_wdata;
  logic                  busy;
  logic                  done;
`ifdef QUANT_SAT_CNT_EN
  logic [15:0]           sat_count;
`endif

  always #5 clk = ~clk;

  quant_wb_ctrl #(.ARRAY_SIZE(AS), .DATA_WIDTH(DW), .OUTPUT_DATA_WIDTH(OW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .base_addr(base_addr),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
    .quant_in(quant_in), .quant_out(quant_out),
    .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .busy(busy), .done(done)
`ifdef QUANT_SAT_CNT_EN
    , .sat_count(sat_count)
`endif
  );

  // Q16.16 quantizer: drop 16 fraction bits, clamp to signed 32-bit range.
  function automatic logic [OW-1:0] quantize(input logic [ACC_W-1:0] x);
    logic signed [ACC_W-1:0] s;
    s = $signed(x) >>> 16;
    if (s > 69'sh7FFFFFFF)       return 32'h7FFFFFFF;
    else if (s < -69'sh80000000) return 32'h80000000;
    else                         return s[OW-1:0];
  endfunction

  function automatic logic [AS*OW-1:0] quant_row(input logic [AS*ACC_W-1:0] r);
    logic [AS*OW-1:0] q;
    q = '0;
    for (int i = 0; i < AS; i++) q[i*OW +: OW] = quantize(r[i*ACC_W +: ACC_W]);
    return q;
  endfunction

  always_comb begin
    quant_out = '0;
    quant_out = quant_row(quant_in);
  end

  function automatic logic [AS*ACC_W-1:0] make_row(input int mode);
    logic [AS*ACC_W-1:0] r;
    logic [95:0]         w;
    r = '0;
    for (int i = 0; i < AS; i++) begin
      w = {$urandom(), $urandom(), $urandom()};
      if (mode == 1) begin
        if (i < 3)       r[i*ACC_W +: ACC_W] = {{(ACC_W-48){1'b0}}, 48'hFFFF_FFFF_FFFF};
        else if (i == 3) r[i*ACC_W +: ACC_W] = {{(ACC_W-61){1'b1}}, 61'h0};
        else             r[i*ACC_W +: ACC_W] = {{(ACC_W-24){w[23]}}, w[23:0]};
      end else if (w[95:94] == 2'b00) begin
        r[i*ACC_W +: ACC_W] = w[ACC_W-1:0];
      end else begin
        r[i*ACC_W +: ACC_W] = {{(ACC_W-40){w[39]}}, w[39:0]};
      end
    end
    return r;
  endfunction

  function automatic int count_sat(input logic [AS*OW-1:0] q);
    int c;
    c = 0;
    for (int i = 0; i < AS; i++)
      if (q[i*OW +: OW] == 32'h7FFFFFFF || q[i*OW +: OW] == 32'h80000000) c++;
    return c;
  endfunction

  typedef struct {
    logic [AW-1:0]    addr;
    logic [AS*OW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   wr_cyc[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   wr_cnt = 0;
  int   sat_model = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_row(input string nm, input logic [AS*OW-1:0] act, input logic [AS*OW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      for (int k = 0; k < AS; k++) begin
        if (act[k*OW +: OW] !== exp[k*OW +: OW]) begin
          $display("FAIL %s word %0d: got %h expected %h (t=%0t)", nm, k, act[k*OW +: OW], exp[k*OW +: OW], $time);
          break;
        end
      end
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && sram_wen) begin
      wr_cnt++;
      wr_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got write to %0h expected none (t=%0t)", sram_addr, $time);
      end else begin
        e = sb.pop_front();
        chk("sram_addr", 64'(sram_addr), 64'(e.addr));
        chk_row("sram_wdata", sram_wdata, e.data);
      end
    end
  end

  // vpct < 0 selects the alternating 1,0,1,... valid pattern.
  task automatic run_job(input int n, input logic [AW-1:0] base, input int vpct, input int mode);
    int   sent;
    int   budget;
    int   start_cyc;
    int   done_cyc;
    exp_t e;
    @(negedge clk);
    chk("busy_idle", 64'(busy), 64'd0);
    wr_cnt    = 0;
    wr_cyc.delete();
    sat_model = 0;
    start     = 1'b1;
    num_rows  = n[AW-1:0];
    base_addr = base;
    acc_valid = 1'b0;
    @(posedge clk);
    #1 start_cyc = cyc;
    if (n == 0) begin
      @(negedge clk);
      #1 start = 1'b0;
      chk("zero_done", 64'(done), 64'd1);
      chk("zero_busy", 64'(busy), 64'd1);
`ifdef QUANT_SAT_CNT_EN
      chk("zero_sat", 64'(sat_count), 64'd0);
`endif
      @(negedge clk);
      #1;
      chk("zero_done_end", 64'(done), 64'd0);
      chk("zero_busy_end", 64'(busy), 64'd0);
      chk("zero_writes", 64'(wr_cnt), 64'd0);
      return;
    end
    sent   = 0;
    budget = 0;
    while (sent < n && budget < 40*n + 100) begin
      @(negedge clk);
      start     = ($urandom_range(0, 3) == 0);
      num_rows  = AW'($urandom());
      base_addr = AW'($urandom());
      acc_valid = (vpct < 0) ? (budget % 2 == 0) : ($urandom_range(1, 100) <= vpct);
      acc_data  = make_row(mode);
      #1;
      chk("acc_ready_run", 64'(acc_ready), 64'd1);
      if (acc_valid) begin
        e.addr = base + sent[AW-1:0];
        e.data = quant_row(acc_data);
        sb.push_back(e);
        sat_model = sat_model + count_sat(e.data);
        if (sat_model > 65535) sat_model = 65535;
        sent++;
      end
      budget++;
    end
    if (sent < n) begin
      tests++;
      fails++;
      $display("FAIL job_timeout: got %0d rows accepted expected %0d", sent, n);
    end
    @(posedge clk);
    @(negedge clk);
    #1 start = 1'b0;
    acc_valid = 1'b0;
    chk("drain_done", 64'(done), 64'd0);
    chk("drain_busy", 64'(busy), 64'd1);
    chk("drain_ready", 64'(acc_ready), 64'd0);
    @(negedge clk);
    #1 done_cyc = cyc;
    chk("done_pulse", 64'(done), 64'd1);
    chk("done_busy", 64'(busy), 64'd1);
    if (wr_cyc.size() > 0) chk("done_after_last_write", 64'(done_cyc), 64'(wr_cyc[wr_cyc.size()-1] + 1));
    if (vpct == 100 && wr_cyc.size() == n) begin
      chk("first_write_cycle", 64'(wr_cyc[0]), 64'(start_cyc + 1));
      for (int i = 1; i < n; i++) chk("back_to_back", 64'(wr_cyc[i]), 64'(wr_cyc[i-1] + 1));
    end
`ifdef QUANT_SAT_CNT_EN
    chk("sat_count", 64'(sat_count), 64'(sat_model));
    if (mode == 1 && n == 2) chk("sat_count_8", 64'(sat_count), 64'd8);
`endif
    @(negedge clk);
    #1;
    chk("done_end", 64'(done), 64'd0);
    chk("busy_end", 64'(busy), 64'd0);
    chk("write_count", 64'(wr_cnt), 64'(n));
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_done"}, 64'(done), 64'd0);
    chk({nm, "_wen"}, 64'(sram_wen), 64'd0);
    chk({nm, "_ready"}, 64'(acc_ready), 64'd0);
    chk({nm, "_addr"}, 64'(sram_addr), 64'd0);
    chk_row({nm, "_wdata"}, sram_wdata, '0);
`ifdef QUANT_SAT_CNT_EN
    chk({nm, "_sat"}, 64'(sat_count), 64'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    #1 rst = 1'b1;
    #2;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_job(4, 10'h010, 100, 0);
    run_job(3, 10'h000, -1, 0);
    run_job(3, 10'h3FE, 100, 0);
    run_job(0, 10'h055, 100, 0);

    // Reset after two of five rows have been accepted.
    @(negedge clk);
    start = 1'b1; num_rows = 10'd5; base_addr = 10'h020; acc_valid = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 1'b0; acc_valid = 1'b1; acc_data = make_row(0);
      #1;
      e.addr = 10'h020 + i[AW-1:0];
      e.data = quant_row(acc_data);
      sb.push_back(e);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("midjob_reset");
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wr_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("post_reset_ready", 64'(acc_ready), 64'd0);
      chk("post_reset_busy", 64'(busy), 64'd0);
    end
    chk("post_reset_writes", 64'(wr_cnt), 64'd0);
    acc_valid = 1'b0;
    run_job(5, 10'h020, 100, 0);

    run_job(2, 10'h100, 100, 1);
    run_job(0, 10'h000, 100, 0);

    for (int j = 0; j < 8; j++)
      run_job($urandom_range(1, 12), AW'($urandom()), $urandom_range(30, 100), 0);
    run_job(6, 10'h3FC, 60, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
